ula_arbiter: RTL and testbench

Shares the single 8-bit ALU (ops ADD/SUB/SLT/NOT, result + COND flag) between two requesters, e.g. the main execute stage (port 0) and the branch/address unit (port 1). Each request is accepted with a valid/ready handshake and its operands are registered. The shared ALU is then driven for one cycle, and the result is returned on the winner's response channel with valid/ready backpressure. This block is the only driver of the ALU inputs.

---
 rtl/ula_pkg.sv | 19 +
 rtl/rr_arb2.sv | 20 ++
 rtl/ula_arbiter.sv | 120 ++++++++++++
 tb/tb_ula_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared op codes, FSM encodings and datapath width for the ALU arbiter
package ula_pkg;

  localparam int ULA_W = 8;

  typedef enum logic [1:0] {
    ULA_ADD = 2'b00,
    ULA_SUB = 2'b01,
    ULA_SLT = 2'b10,
    ULA_NOT = 2'b11
  } ula_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } ula_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way picker, round-robin or fixed priority on ties
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       rr_en,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    if (req == 2'b11) begin
      gnt_id = rr_en ? ~last_grant : 1'b0;
    end else begin
      gnt_id = req[1];
    end
  end

endmodule

// File: rtl/ula_arbiter.sv
// rtl/ula_arbiter.sv - shares one 8-bit ALU between two valid/ready requesters
module ula_arbiter
  import ula_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [ULA_W-1:0] req0_d1,
  input  logic [ULA_W-1:0] req0_d2,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [ULA_W-1:0] req1_d1,
  input  logic [ULA_W-1:0] req1_d2,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [ULA_W-1:0] rsp_result,
  output logic             rsp_cond,
  output logic [ULA_W-1:0] ula_d1,
  output logic [ULA_W-1:0] ula_d2,
  output logic [1:0]       ula_ctrl,
  input  logic [ULA_W-1:0] ula_res,
  input  logic             ula_cond,
  output logic             busy,
  output logic             grant_id
);

  ula_state_e       state, state_nxt;
  ula_op_e          op_r;
  logic [ULA_W-1:0] d1_r, d2_r;
  logic             last_grant;
  logic             gnt_valid, gnt_id;
  logic             accept, rsp_hs;

  rr_arb2 u_rr_arb2 (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .rr_en      (RR_EN),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = 1'b1;
    accept     = 1'b0;
    rsp_hs     = 1'b0;
    case (state)
      S_IDLE: begin
        busy       = 1'b0;
        accept     = gnt_valid;
        req0_ready = gnt_valid & ~gnt_id;
        req1_ready = gnt_valid & gnt_id;
        if (gnt_valid) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp0_valid = ~grant_id;
        rsp1_valid = grant_id;
        rsp_hs     = grant_id ? rsp1_ready : rsp0_ready;
        // Returning to IDLE takes the edge, so no accept overlaps the response handshake.
        if (rsp_hs) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        busy      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_r       <= ULA_ADD;
      d1_r       <= '0;
      d2_r       <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      rsp_result <= '0;
      rsp_cond   <= 1'b0;
    end else begin
      if (accept) begin
        op_r       <= ula_op_e'(gnt_id ? req1_op : req0_op);
        d1_r       <= gnt_id ? req1_d1 : req0_d1;
        d2_r       <= gnt_id ? req1_d2 : req0_d2;
        grant_id   <= gnt_id;
        last_grant <= gnt_id;
      end
      if (state == S_EXEC) begin
        rsp_result <= ula_res;
        rsp_cond   <= ula_cond;
      end
    end
  end

  // The operand registers drive the ALU directly, so its inputs only move on accept.
  assign ula_d1   = d1_r;
  assign ula_d2   = d2_r;
  assign ula_ctrl = op_r;

endmodule

// File: tb/tb_ula_arbiter.sv
// tb/tb_ula_arbiter.sv - directed self-checking bench for ula_arbiter with an ALU model attached
module tb_ula_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [1:0] req0_op = 2'b00, req1_op = 2'b00;
  logic [7:0] req0_d1 = 8'h00, req0_d2 = 8'h00, req1_d1 = 8'h00, req1_d2 = 8'h00;
  logic       rsp0_ready = 1'b1, rsp1_ready = 1'b1;

  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_cond, busy, grant_id;
  logic [7:0] rsp_result, ula_d1, ula_d2, ula_res;
  logic [1:0] ula_ctrl;
  logic       ula_cond;

  logic       req0_ready_f, req1_ready_f, rsp0_valid_f, rsp1_valid_f, rsp_cond_f, busy_f, grant_id_f;
  logic [7:0] rsp_result_f, ula_d1_f, ula_d2_f, ula_res_f;
  logic [1:0] ula_ctrl_f;
  logic       ula_cond_f;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  function automatic logic [8:0] alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   alu = {1'b0, a + b};
      2'b01:   alu = {1'b0, a - b};
      2'b10:   alu = {($signed(a) < $signed(b)), 8'h00};
      default: alu = {1'b0, ~a};
    endcase
  endfunction

  assign {ula_cond, ula_res}     = alu(ula_ctrl, ula_d1, ula_d2);
  assign {ula_cond_f, ula_res_f} = alu(ula_ctrl_f, ula_d1_f, ula_d2_f);

  ula_arbiter #(.RR_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_d1(req0_d1), .req0_d2(req0_d2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_d1(req1_d1), .req1_d2(req1_d2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_cond(rsp_cond),
    .ula_d1(ula_d1), .ula_d2(ula_d2), .ula_ctrl(ula_ctrl), .ula_res(ula_res), .ula_cond(ula_cond),
    .busy(busy), .grant_id(grant_id)
  );

  ula_arbiter #(.RR_EN(1'b0)) dut_fixed (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready_f), .req0_op(req0_op), .req0_d1(req0_d1), .req0_d2(req0_d2),
    .req1_valid(req1_valid), .req1_ready(req1_ready_f), .req1_op(req1_op), .req1_d1(req1_d1), .req1_d2(req1_d2),
    .rsp0_valid(rsp0_valid_f), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid_f), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result_f), .rsp_cond(rsp_cond_f),
    .ula_d1(ula_d1_f), .ula_d2(ula_d2_f), .ula_ctrl(ula_ctrl_f), .ula_res(ula_res_f), .ula_cond(ula_cond_f),
    .busy(busy_f), .grant_id(grant_id_f)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsp0v"}, rsp0_valid, 0);
    chk({tag, "_rsp1v"}, rsp1_valid, 0);
    chk({tag, "_res"}, rsp_result, 0);
    chk({tag, "_cond"}, rsp_cond, 0);
    chk({tag, "_ud1"}, ula_d1, 0);
    chk({tag, "_ud2"}, ula_d2, 0);
    chk({tag, "_uctrl"}, ula_ctrl, 0);
    chk({tag, "_gid"}, grant_id, 0);
  endtask

  // One full transaction on port p with both response readies high.
  task automatic txn(input string tag, input bit p, input logic [1:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] er, input logic ec);
    int n;
    @(negedge clk);
    if (p) begin req1_valid = 1; req1_op = op; req1_d1 = a; req1_d2 = b; end
    else   begin req0_valid = 1; req0_op = op; req0_d1 = a; req0_d2 = b; end
    #1;
    n = 0;
    while (((p ? req1_ready : req0_ready) == 1'b0) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "_accept"}, p ? req1_ready : req0_ready, 1);
    chk({tag, "_other_ready"}, p ? req0_ready : req1_ready, 0);
    @(posedge clk); #1;
    if (p) req1_valid = 0; else req0_valid = 0;
    @(negedge clk);
    chk({tag, "_exec_busy"}, busy, 1);
    chk({tag, "_exec_rspv"}, {rsp1_valid, rsp0_valid}, 0);
    chk({tag, "_ula_in"}, {ula_ctrl, ula_d1, ula_d2}, {op, a, b});
    chk({tag, "_gid"}, grant_id, p);
    @(negedge clk);
    chk({tag, "_rspv"}, {rsp1_valid, rsp0_valid}, p ? 2'b10 : 2'b01);
    chk({tag, "_res"}, rsp_result, er);
    chk({tag, "_cond"}, rsp_cond, ec);
    chk({tag, "_resp_busy"}, busy, 1);
  endtask

  initial begin
    int n;
    bit exp_g;

    // reset state
    @(negedge clk); @(negedge clk);
    chk_idle_outputs("rst");
    chk("rst_rdy", {req1_ready, req0_ready}, 0);
    reset_n = 1;

    // 1: port 0 ADD
    txn("t1_add", 0, 2'b00, 8'h05, 8'h03, 8'h08, 0);
    @(negedge clk);
    chk("t1_back_idle", {busy, rsp0_valid}, 0);

    // 2: port 1 SUB then SLT, plus SLT false and NOT on port 1
    txn("t2_sub", 1, 2'b01, 8'h02, 8'h05, 8'hFD, 0);
    txn("t2_slt_t", 1, 2'b10, 8'hFF, 8'h01, 8'h00, 1);
    txn("t2_slt_f", 1, 2'b10, 8'h01, 8'hFF, 8'h00, 0);
    txn("t2_slt_eq", 0, 2'b10, 8'h80, 8'h80, 8'h00, 0);
    txn("t2_not", 1, 2'b11, 8'hA5, 8'h00, 8'h5A, 0);

    // 3: continuous tie; last grant was port 1 so order is 0,1,0,1
    @(negedge clk);
    req0_valid = 1; req0_op = 2'b00; req0_d1 = 8'h10; req0_d2 = 8'h01;
    req1_valid = 1; req1_op = 2'b11; req1_d1 = 8'h0F; req1_d2 = 8'h33;
    for (int k = 0; k < 4; k++) begin
      exp_g = k[0];
      #1;
      n = 0;
      while (!(req0_ready | req1_ready) && n < 10) begin @(negedge clk); #1; n++; end
      chk("t3_one_ready", {req1_ready, req0_ready}, exp_g ? 2'b10 : 2'b01);
      chk("t3_fixed_ready", {req1_ready_f, req0_ready_f}, 2'b01);
      @(negedge clk);
      chk("t3_gid", grant_id, exp_g);
      chk("t3_fixed_gid", grant_id_f, 0);
      @(negedge clk);
      chk("t3_rspv", {rsp1_valid, rsp0_valid}, exp_g ? 2'b10 : 2'b01);
      chk("t3_res", rsp_result, exp_g ? 8'hF0 : 8'h11);
      chk("t3_fixed_res", {rsp0_valid_f, rsp_result_f}, {1'b1, 8'h11});
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk); @(negedge clk);

    // 4: backpressure on port 0 with port 1 waiting
    @(negedge clk);
    req0_valid = 1; req0_op = 2'b00; req0_d1 = 8'h7F; req0_d2 = 8'h01; rsp0_ready = 0;
    #1;
    chk("t4_accept", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 1; req1_op = 2'b01; req1_d1 = 8'h09; req1_d2 = 8'h04;
    @(negedge clk);
    chk("t4_exec_no_rdy1", req1_ready, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_hold_v", {rsp1_valid, rsp0_valid}, 2'b01);
      chk("t4_hold_res", {rsp_cond, rsp_result}, {1'b0, 8'h80});
      chk("t4_no_rdy1", req1_ready, 0);
    end
    rsp0_ready = 1;
    #1;
    chk("t4_hs_no_rdy1", req1_ready, 0);
    @(negedge clk);
    rsp0_ready = 0;
    #1;
    chk("t4_idle", {busy, rsp0_valid}, 0);
    chk("t4_p1_accept", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 0;
    @(negedge clk); @(negedge clk);
    chk("t4_p1_rsp", {rsp1_valid, rsp_result, rsp_cond}, {1'b1, 8'h05, 1'b0});
    rsp0_ready = 1;
    @(negedge clk);

    // 5: reset during EXEC
    @(negedge clk);
    req0_valid = 1; req0_op = 2'b00; req0_d1 = 8'h22; req0_d2 = 8'h11;
    @(posedge clk); #1;
    req0_valid = 0;
    @(negedge clk);
    chk("t5_exec_busy", busy, 1);
    #2 reset_n = 0;
    #1;
    chk_idle_outputs("t5_rst");
    @(negedge clk);
    reset_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_no_rsp", {busy, rsp1_valid, rsp0_valid}, 0);
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("t5_tie_p0", {req1_ready, req0_ready}, 2'b01);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk); @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
